// File: rtl/caliptra_async_req_arb_pkg.sv
// caliptra_async_req_arb_pkg
//   Shared types and constants for the asynchronous request arbiter.
//   - arb_state_e             : arbiter FSM states
//   - ARB_TIMEOUT_CYC_DEFAULT : default WAIT-state watchdog limit in clk cycles
package caliptra_async_req_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_e;

    localparam int unsigned ARB_TIMEOUT_CYC_DEFAULT = 1024;

endpackage

// File: rtl/caliptra_2ff_sync.sv
// caliptra_2ff_sync
//   Two-flop synchroniser for a bus of independent level signals.
// Ports:
//   clk    in   sampling clock
//   rst_b  in   asynchronous active-low reset, both flops load RST_VAL
//   din    in   WIDTH  unsynchronised levels
//   dout   out  WIDTH  synchronised levels, 2 clk latency
module caliptra_2ff_sync #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/caliptra_rr_arb_pick.sv
// caliptra_rr_arb_pick
//   Combinational round-robin picker: selects the first eligible requester
//   at or after rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   eligible  in   NUM_REQ          candidate requesters
//   rr_ptr    in   $clog2(NUM_REQ)  highest-priority index
//   winner    out  $clog2(NUM_REQ)  selected index (0 when none)
//   any       out  1                at least one candidate
module caliptra_rr_arb_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    // One spare bit so rr_ptr + offset cannot overflow before the wrap.
    logic [IDW:0] idx;

    // Scanning from the farthest offset back to offset 0 lets the closest
    // eligible requester overwrite the others without an early exit.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(NUM_REQ)) begin
                idx = idx - (IDW + 1)'(NUM_REQ);
            end
            if (eligible[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/caliptra_async_req_arb.sv
// caliptra_async_req_arb
//   Arbitrates NUM_REQ asynchronous 4-phase req/ack requesters for a single
//   shared resource in the clk domain. Requests are synchronised, a
//   round-robin FSM grants one requester, pulses res_start_o, waits for
//   res_done_i and then holds a level ack until that requester drops req.
// Optional feature macro: CALIPTRA_ASYNC_ARB_TIMEOUT_EN
//   Enables a WAIT-state watchdog of TIMEOUT_CYC cycles with a sticky
//   err_timeout_o; without it err_timeout_o is tied low and WAIT is unbounded.
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   req_async_i    in   NUM_REQ          unsynchronised level requests
//   ack_o          out  NUM_REQ          registered level acks
//   gnt_o          out  NUM_REQ          one-hot grant, START..WAIT
//   gnt_id_o       out  $clog2(NUM_REQ)  index of current grant
//   res_start_o    out  1                one-cycle resource start pulse
//   res_done_i     in   1                one-cycle resource completion pulse
//   busy_o         out  1                FSM not idle
//   err_timeout_o  out  1                sticky watchdog error
module caliptra_async_req_arb
    import caliptra_async_req_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_async_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
    output logic                       res_start_o,
    input  logic                       res_done_i,
    output logic                       busy_o,
    output logic                       err_timeout_o
);

    localparam int unsigned        IDW     = $clog2(NUM_REQ);
    localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_LSB = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("caliptra_async_req_arb: NUM_REQ must be 2..16 and TIMEOUT_CYC >= 1");
    end

    arb_state_e         state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     winner;
    logic               any_eligible;
    logic [NUM_REQ-1:0] req_sync;
    logic [NUM_REQ-1:0] eligible;
    logic               rst_b;

    assign rst_b = ~rst;

    caliptra_2ff_sync #(
        .WIDTH   (NUM_REQ),
        .RST_VAL ('0)
    ) u_req_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .din   (req_async_i),
        .dout  (req_sync)
    );

    // A requester still holding its ack has not finished the 4-phase
    // handshake, so it must not be considered for a new grant.
    assign eligible = req_sync & ~ack_o;

    caliptra_rr_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .any      (any_eligible)
    );

    assign busy_o = (state != ARB_IDLE);

`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign err_timeout_o = 1'b0;
`endif

    // gnt_id_o is kept after the grant ends because the ACK state uses it
    // to watch the owning requester's req line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            res_start_o <= 1'b0;
            ack_o       <= '0;
`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            err_timeout_o <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_eligible) begin
                        state       <= ARB_START;
                        gnt_o       <= GNT_LSB << winner;
                        gnt_id_o    <= winner;
                        res_start_o <= 1'b1;
                        rr_ptr      <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                    end
                end
                ARB_START: begin
                    res_start_o <= 1'b0;
                    state       <= ARB_WAIT;
`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ARB_WAIT: begin
                    if (res_done_i) begin
                        ack_o[gnt_id_o] <= 1'b1;
                        gnt_o           <= '0;
                        state           <= ARB_ACK;
                    end
`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
                    // wait_cnt holds the number of completed WAIT cycles,
                    // so the limit fires at the end of WAIT cycle TIMEOUT_CYC.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_timeout_o   <= 1'b1;
                        ack_o[gnt_id_o] <= 1'b1;
                        gnt_o           <= '0;
                        state           <= ARB_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ARB_ACK: begin
                    if (!req_sync[gnt_id_o]) begin
                        ack_o <= '0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_async_req_arb.sv
// tb_caliptra_async_req_arb
//   Self-checking bench for caliptra_async_req_arb (NUM_REQ=4, TIMEOUT_CYC=8):
//   reset values, a table-driven single-request handshake, round-robin order,
//   early withdraw, drop during WAIT, reset mid-WAIT, watchdog cases when
//   CALIPTRA_ASYNC_ARB_TIMEOUT_EN is defined, and a randomized run against a
//   transaction-level reference model.
`timescale 1ns/1ps
module tb_caliptra_async_req_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    localparam int W_START = 0;
    localparam int W_NOACK = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] ack;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         start;
    logic         busy;
    logic         err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        logic         start;
        logic [N-1:0] ack;
        logic         busy;
    } vec_t;

    vec_t vecs[10];

    // reference model state: who owns the resource, who holds an ack
    int           m_owner;
    int           m_ack_holder;
    int           m_ptr;
    int           m_last_id;
    bit           m_fresh;
    int           m_wait;
    bit           m_err;
    logic [N-1:0] m_pipe;
    logic [N-1:0] m_sync;

    caliptra_async_req_arb #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_async_i   (req),
        .ack_o         (ack),
        .gnt_o         (gnt),
        .gnt_id_o      (gnt_id),
        .res_start_o   (start),
        .res_done_i    (done),
        .busy_o        (busy),
        .err_timeout_o (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitFor(input int what, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            case (what)
                W_START: seen = start;
                W_NOACK: seen = (ack == '0);
                default: seen = 1'b0;
            endcase
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL wait_%0d: event not seen within %0d cycles, required seen", what, budget);
        end
    endtask

    // Reference model: one clock edge, using the inputs present at the edge.
    task automatic modelEdge(input logic [N-1:0] r, input logic d);
        if (m_owner < 0 && m_ack_holder < 0) begin
            for (int k = 0; k < N; k++) begin
                int cand;
                cand = (m_ptr + k) % N;
                if (m_owner < 0 && m_sync[cand]) m_owner = cand;
            end
            if (m_owner >= 0) begin
                m_fresh   = 1'b1;
                m_ptr     = (m_owner + 1) % N;
                m_last_id = m_owner;
            end
        end else if (m_owner >= 0) begin
            if (m_fresh) begin
                m_fresh = 1'b0;
                m_wait  = 0;
            end else begin
                m_wait++;
                if (d) begin
                    m_ack_holder = m_owner;
                    m_owner      = -1;
                end
`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
                else if (m_wait >= TO) begin
                    m_err        = 1'b1;
                    m_ack_holder = m_owner;
                    m_owner      = -1;
                end
`endif
            end
        end else begin
            if (!m_sync[m_ack_holder]) m_ack_holder = -1;
        end
        m_sync = m_pipe;
        m_pipe = r;
    endtask

    initial begin
        bit           seen;
        int           ack_len;
        bit           saw_bad;
        logic [N-1:0] nreq;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_ack;
        logic         exp_start;
        logic         exp_busy;

        // single request on line 2; done in the START cycle must be ignored
        vecs[0] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1};
        vecs[3] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1};
        vecs[4] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1};
        vecs[5] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1};
        vecs[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1};
        vecs[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1};
        vecs[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[9] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};

        // ---- reset values
        doReset();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_gnt_id", gnt_id, 0);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);

        // ---- table: single request handshake
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].req, vecs[i].done);
            tick();
            checkOutput($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            checkOutput($sformatf("vec%0d_start", i), start, vecs[i].start);
            checkOutput($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            if (vecs[i].gnt != '0) checkOutput($sformatf("vec%0d_gnt_id", i), gnt_id, 2);
        end

        // ---- round robin with all requesters following the 4-phase protocol
        doReset();
        applyStimulus(4'b1111, 1'b0);
        for (int g = 0; g < 5; g++) begin
            waitFor(W_START, 20, seen);
            checkOutput($sformatf("rr%0d_gnt_id", g), gnt_id, g % N);
            checkOutput($sformatf("rr%0d_gnt", g), gnt, 32'(1 << (g % N)));
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checkOutput($sformatf("rr%0d_ack", g), ack, 32'(1 << (g % N)));
            req[g % N] = 1'b0;
            waitFor(W_NOACK, 10, seen);
            req[g % N] = 1'b1;
        end

        // ---- early withdraw: req[1] pulses one cycle while req[0] is served
        doReset();
        applyStimulus(4'b0001, 1'b0);
        waitFor(W_START, 10, seen);
        tick();
        req = 4'b0011;
        tick();
        req = 4'b0001;
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("ew_ack0", ack, 4'b0001);
        req = 4'b0000;
        saw_bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ack[1] || gnt[1] || start) saw_bad = 1'b1;
        end
        checkOutput("ew_never_served1", saw_bad, 0);
        checkOutput("ew_idle", busy, 0);

        // ---- drop during WAIT: transfer still completes
        doReset();
        applyStimulus(4'b1000, 1'b0);
        waitFor(W_START, 10, seen);
        checkOutput("drop_gnt", gnt, 4'b1000);
        req = 4'b0000;
`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
        repeat (3) tick();
`else
        repeat (20) tick();
        checkOutput("drop_wait_busy", busy, 1);
        checkOutput("drop_wait_gnt", gnt, 4'b1000);
        checkOutput("drop_no_err", err, 0);
`endif
        done = 1'b1;
        tick();
        done = 1'b0;
        ack_len = 0;
        for (int c = 0; c < 10; c++) begin
            if (ack[3]) ack_len++;
            tick();
        end
        checkOutput("drop_ack_len_1to3", (ack_len >= 1 && ack_len <= 3), 1);
        checkOutput("drop_idle", busy, 0);

        // ---- reset mid-WAIT
        doReset();
        applyStimulus(4'b0100, 1'b0);
        waitFor(W_START, 10, seen);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mrst_gnt", gnt, 0);
        checkOutput("mrst_ack", ack, 0);
        checkOutput("mrst_start", start, 0);
        checkOutput("mrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        waitFor(W_START, 10, seen);
        checkOutput("mrst_regnt_id", gnt_id, 2);
        checkOutput("mrst_regnt_ack", ack, 0);

`ifdef CALIPTRA_ASYNC_ARB_TIMEOUT_EN
        // ---- done in WAIT cycle TO wins over the watchdog
        doReset();
        applyStimulus(4'b0001, 1'b0);
        waitFor(W_START, 10, seen);
        repeat (TO) tick();
        checkOutput("to_edge_err", err, 0);
        checkOutput("to_edge_gnt", gnt, 4'b0001);
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("to_edge_ack", ack, 4'b0001);
        checkOutput("to_edge_err_after", err, 0);

        // ---- no done: watchdog fires at WAIT cycle TO and stays set
        doReset();
        applyStimulus(4'b0001, 1'b0);
        waitFor(W_START, 10, seen);
        repeat (TO) tick();
        checkOutput("to_pre_err", err, 0);
        tick();
        checkOutput("to_err", err, 1);
        checkOutput("to_ack", ack, 4'b0001);
        checkOutput("to_gnt", gnt, 0);
        req = 4'b0000;
        waitFor(W_NOACK, 10, seen);
        repeat (3) tick();
        checkOutput("to_sticky", err, 1);
        checkOutput("to_idle", busy, 0);
`endif

        // ---- randomized run against the reference model
        doReset();
        m_owner      = -1;
        m_ack_holder = -1;
        m_ptr        = 0;
        m_last_id    = 0;
        m_fresh      = 1'b0;
        m_wait       = 0;
        m_err        = 1'b0;
        m_pipe       = '0;
        m_sync       = '0;
        for (int c = 0; c < 1500; c++) begin
            nreq = req;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 1) == 0) nreq[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    nreq[i] = ~nreq[i];
                end
            end
            applyStimulus(nreq, ($urandom_range(0, 3) == 0));
            @(posedge clk);
            modelEdge(req, done);
            #1;
            exp_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            exp_ack   = (m_ack_holder >= 0) ? N'(1 << m_ack_holder) : '0;
            exp_start = (m_owner >= 0) && m_fresh;
            exp_busy  = (m_owner >= 0) || (m_ack_holder >= 0);
            checkOutput($sformatf("rand%0d_gnt_start_ack_busy_err", c),
                        {gnt, start, ack, busy, err},
                        {exp_gnt, exp_start, exp_ack, exp_busy, m_err});
            if (m_owner >= 0) checkOutput($sformatf("rand%0d_gnt_id", c), gnt_id, m_last_id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
